mips_div_unit: RTL and testbench
================================

Name: mips_div_unit

Overview:
- Multi-cycle integer divider for the MIPS core's DIV/DIVU instructions.
- Sits downstream of the EX stage: EX issues operands plus a start pulse, and the core stalls on busy.
- On done, the core writes the results to HI/LO: LO gets the quotient, HI gets the remainder.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥ 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- signed_op  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  WIDTH  rs operand, sampled with start.
- divisor  in  WIDTH  rt operand, sampled with start.
- cancel  in  1  pipeline flush (exception/branch squash); aborts the operation in flight.
- busy  out  1  high from the cycle after start until done or cancel.
- done  out  1  one-cycle pulse; results valid in the same cycle.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, quotient=0, remainder=0, all internal registers 0.
- States: IDLE, CALC, FIX, and an implicit done pulse on the FIX→IDLE edge.
- IDLE, start=1, divisor≠0:
  - Latch |dividend| and |divisor|; absolute value applies only when signed_op=1 and the MSB is set.
  - Latch q_neg = signed_op & (dividend MSB ^ divisor MSB).
  - Latch r_neg = signed_op & dividend MSB.
  - Set cnt=0 and go to CALC.
- IDLE, start=1, divisor=0: go to FIX with the divide-by-zero flag set; no iteration.
- CALC, one step per cycle:
  - Shift the partial remainder left by 1, bringing in the next dividend MSB.
  - Trial subtract the divisor with a WIDTH+1 bit result.
  - Non-negative: keep the difference and shift in q bit 1. Otherwise restore and shift in 0.
  - cnt increments each step. After WIDTH steps (cnt==WIDTH-1 on the last step), go to FIX.
- FIX, single cycle:
  - Negate the quotient if q_neg; negate the remainder if r_neg.
  - Register into quotient/remainder, assert done=1 for exactly this cycle, then go to IDLE.
- Latency:
  - Start accepted in cycle N → done in cycle N+WIDTH+1 (33 for WIDTH=32).
  - Divide-by-zero → done in cycle N+1.
- busy=1 in CALC and FIX, else 0. busy is registered and rises the cycle after start.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified, both modes). This is a deterministic choice; the ISA leaves the result undefined.
- Signed overflow (−2^(WIDTH−1) / −1): falls out of the magnitude path → quotient = 0x80000000, remainder = 0. No special case.
- Remainder sign follows the dividend; a zero remainder is never negated to a non-zero value.
- start while busy: ignored; operands are not re-sampled.
- start and cancel in the same IDLE cycle: cancel wins and start is dropped.
- cancel in CALC or FIX: return to IDLE next cycle. done is not asserted and quotient/remainder keep their previous values.
- quotient/remainder hold their values until the next done; they update only on done.
- Reset mid-operation: immediate return to the reset state; no done.

Decomposition:
- Shared package mips_pkg holds:
  - the state encoding typedef (DIV_IDLE, DIV_CALC, DIV_FIX);
  - the DIV/DIVU funct constants (6'h1A, 6'h1B) used by the decoder to drive signed_op;
  - the default data width.
- One natural sub-module, div_step: combinational shift and trial-subtract for one iteration. It is instantiated once in the CALC datapath and unit-testable on its own.
- Sign fix-up stays inline.

Test Plan:
- DIVU 100/7, start at cycle 0 → busy=1 cycles 1–33, done at cycle 33, quotient=14, remainder=2.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also 7/−2 → q=−3, r=1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU with the same operands → quotient=0, remainder=0x80000000.
- DIVU 0x12345678 / 0 → done at cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678.
- Cancel at cycle 10 of a DIVU 1000/3 → busy low at cycle 11, no done pulse, outputs hold prior values. A new start at cycle 12 (50/5) → done at cycle 45, quotient=10, remainder=0.
- Two edge cases:
  - start pulsed again at cycle 5 mid-operation → ignored, first result correct.
  - rst_n low at cycle 15 → busy=0 and outputs 0 immediately; next start completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Divider state encoding, DIV/DIVU funct codes, default data width.
package mips_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX
    } div_state_t;

    // Decoder helpers: which funct codes go to the divider, and which are signed.
    function automatic logic is_div_funct(
        input logic [5:0] funct
    );
        return (funct == FUNCT_DIV) ||
               (funct == FUNCT_DIVU);
    endfunction

    function automatic logic is_div_signed(
        input logic [5:0] funct
    );
        return funct == FUNCT_DIV;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
// Ports: rem/dvd_bit/dvs in; rem_next and quotient bit q_bit out.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // rem < dvs always holds, so the WIDTH+1 bit difference
    // is negative exactly when its top bit is set.
    assign diff     = {rem, dvd_bit} - {1'b0, dvs};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0]
                            : {rem[WIDTH-2:0], dvd_bit};

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU (LO=quotient, HI=remainder).
// Ports: start/signed_op/dividend/divisor/cancel in; busy/done/quotient/remainder out.
module mips_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t state_q, state_d;

    // quo_q doubles as the dividend shift register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .dvd_bit  (quo_q[WIDTH-1]),
        .dvs      (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign dvd_abs = (signed_op && dividend[WIDTH-1])
                   ? -dividend : dividend;
    assign dvs_abs = (signed_op && divisor[WIDTH-1])
                   ? -divisor : divisor;

    // Negating zero yields zero, so a zero remainder stays zero.
    assign fix_q = q_neg_q ? -quo_q : quo_q;
    assign fix_r = r_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        done    = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    if (divisor == '0) begin
                        // Divide by zero: preload the
                        // final answer, skip iteration.
                        quo_d   = '1;
                        rem_d   = dividend;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DIV_FIX;
                    end else begin
                        quo_d   = dvd_abs;
                        rem_d   = '0;
                        dvs_d   = dvs_abs;
                        q_neg_d = signed_op &
                                  (dividend[WIDTH-1] ^
                                   divisor[WIDTH-1]);
                        r_neg_d = signed_op &
                                  dividend[WIDTH-1];
                        cnt_d   = '0;
                        state_d = DIV_CALC;
                    end
                end
            end

            DIV_CALC: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DIV_FIX;
                    end
                end
            end

            DIV_FIX: begin
                state_d = DIV_IDLE;
                if (!cancel) begin
                    done    = 1'b1;
                    q_out_d = fix_q;
                    r_out_d = fix_r;
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != DIV_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
        end
    end

    // Results show the fixed-up value during the done cycle,
    // then hold from the output registers.
    assign busy      = busy_q;
    assign quotient  = done ? fix_q : q_out_q;
    assign remainder = done ? fix_r : r_out_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit.
// Cycle-level reference model plus directed literal expectations.
module tb_mips_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_chk;
    int n_fail;
    int cyc;
    logic chk_en;

    mips_div_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(
        input string       nm,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Arithmetic reference: {remainder, quotient}.
    function automatic logic [63:0] ref_div(
        input logic         s,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Cycle model: cycles left until done, pending and held results.
    logic        m_busy;
    int          m_left;
    logic [63:0] m_pend;
    logic [63:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_pend <= '0;
            m_out  <= '0;
        end else if (!m_busy) begin
            if (start && !cancel) begin
                m_pend <= ref_div(signed_op, dividend, divisor);
                m_busy <= 1'b1;
                m_left <= (divisor == '0) ? 1 : W + 1;
            end
        end else if (cancel) begin
            m_busy <= 1'b0;
        end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_out  <= m_pend;
        end else begin
            m_left <= m_left - 1;
        end
    end

    logic        e_done;
    logic [63:0] e_res;
    assign e_done = m_busy && (m_left == 1) && !cancel;
    assign e_res  = e_done ? m_pend : m_out;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model busy", 64'(busy), 64'(m_busy));
            chk("model done", 64'(done), 64'(e_done));
            chk("model quotient", 64'(quotient), 64'(e_res[31:0]));
            chk("model remainder", 64'(remainder), 64'(e_res[63:32]));
        end
    end

    int t0;

    task automatic start_op(
        input logic         s,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        @(posedge clk); #1;
        t0        = cyc;
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(
        input string        nm,
        input int           elat,
        input logic [W-1:0] eq,
        input logic [W-1:0] er
    );
        int lat;
        lat = -1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                chk({nm, " q"}, 64'(quotient), 64'(eq));
                chk({nm, " r"}, 64'(remainder), 64'(er));
                break;
            end
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
    endtask

    task automatic run(
        input string        nm,
        input logic         s,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input int           elat,
        input logic [W-1:0] eq,
        input logic [W-1:0] er
    );
        start_op(s, a, b);
        wait_done(nm, elat, eq, er);
    endtask

    int seen_done;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        chk_en    = 1'b0;
        rst_n     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        cancel    = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset q", 64'(quotient), 64'(0));
        chk("reset r", 64'(remainder), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run("divu 100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
            32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33,
            32'hFFFF_FFFD, 32'd1);
        run("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'h8000_0000, 32'd0);
        run("divu big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'd0, 32'h8000_0000);
        run("div -8/4", 1'b1, 32'hFFFF_FFF8, 32'd4, 33,
            32'hFFFF_FFFE, 32'd0);
        run("divu dz", 1'b0, 32'h1234_5678, 32'd0, 1,
            32'hFFFF_FFFF, 32'h1234_5678);
        run("div dz", 1'b1, 32'h8765_4321, 32'd0, 1,
            32'hFFFF_FFFF, 32'h8765_4321);

        // Cancel at cycle 10, restart at cycle 12.
        start_op(1'b0, 32'd1000, 32'd3);
        seen_done = 0;
        while (cyc - t0 < 10) begin
            @(negedge clk);
            if (done) seen_done++;
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        if (done) seen_done++;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        if (done) seen_done++;
        chk("cancel busy", 64'(busy), 64'(0));
        chk("cancel no done", 64'(seen_done), 64'(0));
        chk("cancel hold q", 64'(quotient), 64'(32'hFFFF_FFFF));
        chk("cancel hold r", 64'(remainder), 64'(32'h8765_4321));
        run("restart 50/5", 1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0);

        // Start and cancel together in IDLE: start dropped.
        @(posedge clk); #1;
        start    = 1'b1;
        cancel   = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        @(posedge clk); #1;
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        chk("start+cancel busy", 64'(busy), 64'(0));

        // Second start at cycle 5 is ignored.
        start_op(1'b0, 32'd255, 32'd16);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd1;
        divisor  = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart ignored", 33, 32'd15, 32'd15);

        // Reset at cycle 15 of an operation.
        start_op(1'b1, 32'hFFFF_FF00, 32'd7);
        while (cyc - t0 < 15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 64'(busy), 64'(0));
        chk("mid rst q", 64'(quotient), 64'(0));
        chk("mid rst r", 64'(remainder), 64'(0));
        @(negedge clk);
        chk("mid rst done", 64'(done), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run("after rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 33,
            32'hFFFF_FFF2, 32'hFFFF_FFFE);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
